// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial two's-complement unit: operation modes,
// the carry/borrow tracking states and the MSB signed-overflow rule.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_NEG  = 2'b01,
    MODE_INC  = 2'b10,
    MODE_DEC  = 2'b11
  } mode_e;

  typedef enum logic {
    ST_PEND = 1'b0,
    ST_TAIL = 1'b1
  } state_e;

  // Signed overflow seen at the word MSB, from the input and result sign bits.
  function automatic logic msb_ovf(mode_e m, logic in_msb, logic out_msb);
    logic r;
    r = 1'b0;
    case (m)
      MODE_NEG: r = in_msb & out_msb;
      MODE_INC: r = ~in_msb & out_msb;
      MODE_DEC: r = in_msb & ~out_msb;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/serial_word_counter.sv
// Bit position within the current serial word. Advances only on accepted
// bits and wraps after the MSB; flags the first and last positions.
module serial_word_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic advance,
  output logic first,
  output logic last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_POS = CW'(WIDTH - 1);

  logic [CW-1:0] count;

  // Position register: clears on reset, steps on each accepted bit, wraps at the MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (advance) begin
      if (count == LAST_POS) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  // Position decode for the word boundaries.
  always_comb begin
    first = (count == '0);
    last  = (count == LAST_POS);
  end

endmodule

// File: rtl/serial_twos_comp_unit.sv
// Bit-serial (LSB first) pass / negate / increment / decrement of a WIDTH-bit
// two's-complement word, with one cycle of registered latency and a signed
// overflow flag on the MSB.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_PEND | carry, borrow or first-one still pending (start of word)
//   ST_TAIL | pending event resolved; remaining bits follow a fixed rule
module serial_twos_comp_unit
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in_bit,
  input  logic [1:0] mode,
  output logic       out_valid,
  output logic       out_bit,
  output logic       out_last,
  output logic       ovf
);

  state_e state_q;
  state_e state_d;
  mode_e  mode_q;
  mode_e  mode_eff;
  logic   first;
  logic   last;
  logic   obit_d;
  logic   ovf_d;

  serial_word_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .advance(in_valid),
    .first  (first),
    .last   (last)
  );

  // The mode applied to a bit: live input on the LSB, the latched copy afterwards.
  always_comb begin
    mode_eff = first ? mode_e'(mode) : mode_q;
  end

  // Latch the mode on the LSB so mid-word changes wait for the next word.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= MODE_PASS;
    end else if (in_valid && first) begin
      mode_q <= mode_e'(mode);
    end
  end

  // State register; only accepted bits move the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_PEND;
    end else if (in_valid) begin
      state_q <= state_d;
    end
  end

  // Next state: track whether the carry/borrow/first-one has resolved.
  always_comb begin
    state_d = state_q;
    case (mode_eff)
      MODE_PASS: state_d = ST_PEND;
      MODE_NEG:  if (state_q == ST_PEND && in_bit)  state_d = ST_TAIL;
      MODE_INC:  if (state_q == ST_PEND && !in_bit) state_d = ST_TAIL;
      MODE_DEC:  if (state_q == ST_PEND && in_bit)  state_d = ST_TAIL;
      default:   state_d = ST_PEND;
    endcase
    // Every word starts fresh, so the MSB always returns to PEND.
    if (last) begin
      state_d = ST_PEND;
    end
  end

  // Output decode: result bit for the current input and the MSB overflow.
  always_comb begin
    obit_d = in_bit;
    case (mode_eff)
      MODE_PASS: obit_d = in_bit;
      MODE_NEG:  obit_d = (state_q == ST_PEND) ? in_bit : ~in_bit;
      MODE_INC:  obit_d = (state_q == ST_PEND) ? ~in_bit : in_bit;
      MODE_DEC:  obit_d = (state_q == ST_PEND) ? ~in_bit : in_bit;
      default:   obit_d = in_bit;
    endcase
    ovf_d = last & msb_ovf(mode_eff, in_bit, obit_d);
  end

  // Registered outputs; everything but out_valid is forced low on idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_last  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      out_bit   <= in_valid & obit_d;
      out_last  <= in_valid & last;
      ovf       <= in_valid & ovf_d;
    end
  end

endmodule

// File: tb/tb_serial_twos_comp_unit.sv
// Directed bench for serial_twos_comp_unit at WIDTH=8.
module tb_serial_twos_comp_unit;

  localparam logic [1:0] M_PASS = 2'b00;
  localparam logic [1:0] M_NEG  = 2'b01;
  localparam logic [1:0] M_INC  = 2'b10;
  localparam logic [1:0] M_DEC  = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_bit;
  logic [1:0] mode;
  logic       out_valid;
  logic       out_bit;
  logic       out_last;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  serial_twos_comp_unit #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .mode     (mode),
    .out_valid(out_valid),
    .out_bit  (out_bit),
    .out_last (out_last),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors %0d", errors);
    $fatal(1, "watchdog");
  end

  // Drive one cycle on the falling edge, sample the registered outputs just after the rising edge.
  task automatic step(input logic v, input logic b, input logic [1:0] m,
                      output logic ov, output logic ob, output logic ol, output logic of);
    @(negedge clk);
    in_valid = v;
    in_bit   = b;
    mode     = m;
    @(posedge clk);
    #1;
    ov = out_valid;
    ob = out_bit;
    ol = out_last;
    of = ovf;
  endtask

  // Stream one word; m0 on the LSB, mrest on the remaining bits.
  task automatic run_word(input logic [1:0] m0, input logic [1:0] mrest, input logic [7:0] data,
                          output logic [7:0] res, output logic [7:0] vm,
                          output logic [7:0] lm, output logic [7:0] om);
    logic ov, ob, ol, of;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, data[i], (i == 0) ? m0 : mrest, ov, ob, ol, of);
      res[i] = ob;
      vm[i]  = ov;
      lm[i]  = ol;
      om[i]  = of;
    end
  endtask

  task automatic test_reset();
    logic ov, ob, ol, of;
    reset = 1'b1;
    step(1'b1, 1'b1, M_NEG, ov, ob, ol, of);
    step(1'b1, 1'b1, M_NEG, ov, ob, ol, of);
    checks++;
    if ({ov, ob, ol, of} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0000", {ov, ob, ol, of});
    end
    reset = 1'b0;
    step(1'b0, 1'b0, M_PASS, ov, ob, ol, of);
    checks++;
    if ({ov, ol, of} !== 3'b000) begin
      errors++;
      $display("FAIL idle_outputs got %b exp 000", {ov, ol, of});
    end
  endtask

  task automatic test_vector(input string name, input logic [1:0] m, input logic [7:0] data,
                             input logic [7:0] exp_res, input logic exp_ovf);
    logic [7:0] res, vm, lm, om;
    logic ov, ob, ol, of;
    run_word(m, m, data, res, vm, lm, om);
    checks++;
    if (res !== exp_res) begin
      errors++;
      $display("FAIL %s result got %h exp %h", name, res, exp_res);
    end
    checks++;
    if (lm !== 8'h80 || vm !== 8'hFF) begin
      errors++;
      $display("FAIL %s framing last %h valid %h exp 80 ff", name, lm, vm);
    end
    checks++;
    if (om !== {exp_ovf, 7'b0}) begin
      errors++;
      $display("FAIL %s ovf got %h exp %h", name, om, {exp_ovf, 7'b0});
    end
    step(1'b0, 1'b0, M_PASS, ov, ob, ol, of);
  endtask

  task automatic test_gap();
    logic [7:0] data, res, lm;
    logic ov, ob, ol, of;
    int n;
    data = 8'h06;
    n = 0;
    lm = '0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, data[i], M_NEG, ov, ob, ol, of);
      res[n] = ob; lm[n] = ol; n++;
    end
    for (int g = 0; g < 3; g++) begin
      step(1'b0, g[0], M_INC, ov, ob, ol, of);
      checks++;
      if ({ov, ol, of} !== 3'b000) begin
        errors++;
        $display("FAIL gap_idle cycle %0d got %b exp 000", g, {ov, ol, of});
      end
    end
    for (int i = 3; i < 8; i++) begin
      step(1'b1, data[i], M_INC, ov, ob, ol, of);
      res[n] = ob; lm[n] = ol; n++;
    end
    checks++;
    if (res !== 8'hFA) begin
      errors++;
      $display("FAIL gap_result got %h exp fa", res);
    end
    checks++;
    if (lm !== 8'h80) begin
      errors++;
      $display("FAIL gap_last got %h exp 80", lm);
    end
    step(1'b0, 1'b0, M_PASS, ov, ob, ol, of);
  endtask

  task automatic test_reset_midword();
    logic [7:0] res, vm, lm, om, data;
    logic ov, ob, ol, of;
    data = 8'h5A;
    for (int i = 0; i < 5; i++) step(1'b1, data[i], M_INC, ov, ob, ol, of);
    reset = 1'b1;
    step(1'b1, 1'b1, M_INC, ov, ob, ol, of);
    reset = 1'b0;
    checks++;
    if ({ov, ob, ol, of} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_outputs got %b exp 0000", {ov, ob, ol, of});
    end
    run_word(M_NEG, M_INC, 8'h01, res, vm, lm, om);
    checks++;
    if (res !== 8'hFF) begin
      errors++;
      $display("FAIL midreset_neg01 got %h exp ff", res);
    end
    checks++;
    if (lm !== 8'h80 || vm !== 8'hFF || om !== 8'h00) begin
      errors++;
      $display("FAIL midreset_framing last %h valid %h ovf %h exp 80 ff 00", lm, vm, om);
    end
    run_word(M_PASS, M_NEG, 8'h06, res, vm, lm, om);
    checks++;
    if (res !== 8'h06 || om !== 8'h00) begin
      errors++;
      $display("FAIL mode_toggle_pass got %h ovf %h exp 06 00", res, om);
    end
    step(1'b0, 1'b0, M_PASS, ov, ob, ol, of);
  endtask

  task automatic test_back_to_back();
    logic [7:0] r1, v1, l1, o1, r2, v2, l2, o2;
    logic ov, ob, ol, of;
    run_word(M_INC, M_INC, 8'h01, r1, v1, l1, o1);
    run_word(M_NEG, M_NEG, 8'h01, r2, v2, l2, o2);
    checks++;
    if (r1 !== 8'h02) begin
      errors++;
      $display("FAIL b2b_first got %h exp 02", r1);
    end
    checks++;
    if (r2 !== 8'hFF) begin
      errors++;
      $display("FAIL b2b_second got %h exp ff", r2);
    end
    checks++;
    if ({v1, v2} !== 16'hFFFF || {l1, l2} !== 16'h8080) begin
      errors++;
      $display("FAIL b2b_framing valid %h last %h exp ffff 8080", {v1, v2}, {l1, l2});
    end
    step(1'b0, 1'b0, M_PASS, ov, ob, ol, of);
    checks++;
    if (ov !== 1'b0) begin
      errors++;
      $display("FAIL b2b_tail_valid got %b exp 0", ov);
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    mode     = M_PASS;
    test_reset();
    test_vector("neg06",   M_NEG,  8'h06, 8'hFA, 1'b0);
    test_vector("neg80",   M_NEG,  8'h80, 8'h80, 1'b1);
    test_vector("neg00",   M_NEG,  8'h00, 8'h00, 1'b0);
    test_vector("inc7f",   M_INC,  8'h7F, 8'h80, 1'b1);
    test_vector("incff",   M_INC,  8'hFF, 8'h00, 1'b0);
    test_vector("dec00",   M_DEC,  8'h00, 8'hFF, 1'b0);
    test_vector("dec80",   M_DEC,  8'h80, 8'h7F, 1'b1);
    test_vector("dec05",   M_DEC,  8'h05, 8'h04, 1'b0);
    test_vector("pass81",  M_PASS, 8'h81, 8'h81, 1'b0);
    test_gap();
    test_reset_midword();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
